// File: rtl/tblink_rpc_rsp_engine.sv
// HDL-side TBLink RPC responder: deserializes request frames, presents one call at a time
// to the user method port, and serializes the matching response frame back onto the link.
module tblink_rpc_rsp_engine #(
   parameter int unsigned MAX_PARAMS = 8,
   parameter int unsigned MAX_RSP    = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [7:0]              in_dat,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [7:0]              out_dat,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    req_valid,
   input  logic                    req_ready,
   output logic [7:0]              req_method,
   output logic [7:0]              req_call_id,
   output logic [7:0]              req_nparams,
   output logic [8*MAX_PARAMS-1:0] req_params,
   input  logic                    rsp_valid,
   output logic                    rsp_ready,
   input  logic [7:0]              rsp_len,
   input  logic [8*MAX_RSP-1:0]    rsp_dat,
   output logic [15:0]             err_count
);

   localparam logic [7:0] MaxParamsB = 8'(MAX_PARAMS);
   localparam logic [7:0] MaxRspB    = 8'(MAX_RSP);
   localparam logic [7:0] StatusOk   = 8'h01;
   localparam logic [7:0] StatusErr  = 8'hFF;

   typedef enum logic [3:0] {
      StRxMethod,
      StRxCallId,
      StRxLen,
      StRxParams,
      StDrain,
      StInvoke,
      StWaitRsp,
      StTxStatus,
      StTxCallId,
      StTxLen,
      StTxData
   } state_e;

   state_e                  state_q, state_d;
   logic [7:0]              method_q, method_d;
   logic [7:0]              call_id_q, call_id_d;
   logic [7:0]              nparams_q, nparams_d;
   logic [8*MAX_PARAMS-1:0] params_q, params_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [7:0]              status_q, status_d;
   logic [7:0]              len_q, len_d;
   logic [8*MAX_RSP-1:0]    rsp_q, rsp_d;
   logic [15:0]             err_q, err_d;
   logic                    err_inc;
   logic                    rx_state;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StRxMethod;
         method_q  <= '0;
         call_id_q <= '0;
         nparams_q <= '0;
         params_q  <= '0;
         cnt_q     <= '0;
         status_q  <= '0;
         len_q     <= '0;
         rsp_q     <= '0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         method_q  <= method_d;
         call_id_q <= call_id_d;
         nparams_q <= nparams_d;
         params_q  <= params_d;
         cnt_q     <= cnt_d;
         status_q  <= status_d;
         len_q     <= len_d;
         rsp_q     <= rsp_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      method_d  = method_q;
      call_id_d = call_id_q;
      nparams_d = nparams_q;
      params_d  = params_q;
      cnt_d     = cnt_q;
      status_d  = status_q;
      len_d     = len_q;
      rsp_d     = rsp_q;
      err_inc   = 1'b0;
      rx_state  = 1'b0;
      out_valid = 1'b0;
      out_dat   = 8'h00;
      req_valid = 1'b0;
      rsp_ready = 1'b0;

      unique case (state_q)
         StRxMethod: begin
            rx_state = 1'b1;
            if (in_valid) begin
               method_d = in_dat;
               // Clear old parameters so unused bytes of the next call read as zero.
               params_d = '0;
               state_d  = StRxCallId;
            end
         end
         StRxCallId: begin
            rx_state = 1'b1;
            if (in_valid) begin
               call_id_d = in_dat;
               state_d   = StRxLen;
            end
         end
         StRxLen: begin
            rx_state = 1'b1;
            if (in_valid) begin
               nparams_d = in_dat;
               cnt_d     = 8'h00;
               if (in_dat == 8'h00) begin
                  state_d = StInvoke;
               end else if (in_dat <= MaxParamsB) begin
                  state_d = StRxParams;
               end else begin
                  state_d = StDrain;
               end
            end
         end
         StRxParams: begin
            rx_state = 1'b1;
            if (in_valid) begin
               for (int unsigned k = 0; k < MAX_PARAMS; k++) begin
                  if (cnt_q == 8'(k)) params_d[8*k +: 8] = in_dat;
               end
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == nparams_q - 8'd1) state_d = StInvoke;
            end
         end
         StDrain: begin
            rx_state = 1'b1;
            if (in_valid) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == nparams_q - 8'd1) begin
                  err_inc  = 1'b1;
                  status_d = StatusErr;
                  len_d    = 8'h00;
                  state_d  = StTxStatus;
               end
            end
         end
         StInvoke: begin
            req_valid = 1'b1;
            if (req_ready) state_d = StWaitRsp;
         end
         StWaitRsp: begin
            rsp_ready = 1'b1;
            if (rsp_valid) begin
               rsp_d    = rsp_dat;
               status_d = StatusOk;
               // Oversized returns are truncated but still reported as ok.
               if (rsp_len > MaxRspB) begin
                  len_d   = MaxRspB;
                  err_inc = 1'b1;
               end else begin
                  len_d = rsp_len;
               end
               state_d = StTxStatus;
            end
         end
         StTxStatus: begin
            out_valid = 1'b1;
            out_dat   = status_q;
            if (out_ready) state_d = StTxCallId;
         end
         StTxCallId: begin
            out_valid = 1'b1;
            out_dat   = call_id_q;
            if (out_ready) state_d = StTxLen;
         end
         StTxLen: begin
            out_valid = 1'b1;
            out_dat   = len_q;
            if (out_ready) begin
               cnt_d   = 8'h00;
               state_d = (len_q == 8'h00) ? StRxMethod : StTxData;
            end
         end
         StTxData: begin
            out_valid = 1'b1;
            for (int unsigned k = 0; k < MAX_RSP; k++) begin
               if (cnt_q == 8'(k)) out_dat = rsp_q[8*k +: 8];
            end
            if (out_ready) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == len_q - 8'd1) state_d = StRxMethod;
            end
         end
         default: state_d = StRxMethod;
      endcase

      err_d = (err_inc && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;
   end

   assign in_ready    = rx_state && !reset;
   assign req_method  = method_q;
   assign req_call_id = call_id_q;
   assign req_nparams = nparams_q;
   assign req_params  = params_q;
   assign err_count   = err_q;

endmodule

// File: tb/tb_tblink_rpc_rsp_engine.sv
// Randomized self-checking bench for tblink_rpc_rsp_engine; expected frames come from a
// queue-based model of the request/response protocol.
module tb_tblink_rpc_rsp_engine;

   localparam int unsigned MP = 8;
   localparam int unsigned MR = 4;

   logic            clock = 1'b0;
   logic            reset;
   logic [7:0]      in_dat;
   logic            in_valid;
   logic            in_ready;
   logic [7:0]      out_dat;
   logic            out_valid;
   logic            out_ready;
   logic            req_valid;
   logic            req_ready;
   logic [7:0]      req_method;
   logic [7:0]      req_call_id;
   logic [7:0]      req_nparams;
   logic [8*MP-1:0] req_params;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [7:0]      rsp_len;
   logic [8*MR-1:0] rsp_dat;
   logic [15:0]     err_count;

   tblink_rpc_rsp_engine #(.MAX_PARAMS(MP), .MAX_RSP(MR)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_dat     (in_dat),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_dat    (out_dat),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_method (req_method),
      .req_call_id(req_call_id),
      .req_nparams(req_nparams),
      .req_params (req_params),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_len    (rsp_len),
      .rsp_dat    (rsp_dat),
      .err_count  (err_count)
   );

   always #5 clock = ~clock;

   int cycle = 0;
   always @(posedge clock) cycle <= cycle + 1;

   int errors = 0;
   int checks = 0;
   int exp_err = 0;
   logic [7:0] pb [256];
   logic [7:0] rb [256];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap_pct, output int acc_cycle);
      bit done = 0;
      int budget = 200;
      while (!done && budget > 0) begin
         @(negedge clock);
         in_dat   = b;
         in_valid = ($urandom_range(99) >= gap_pct);
         #1;
         if (in_valid && in_ready) done = 1;
         acc_cycle = cycle;
         @(posedge clock);
         budget--;
      end
      if (!done) check("in_timeout", 0, 1);
   endtask

   task automatic run_txn(input logic [7:0] method, input logic [7:0] cid, input int n,
                          input int rlen, input int gap_pct, input int ordy_pct, input bit fast);
      logic [7:0] expq [$];
      logic [7:0] gotq [$];
      logic [8*MP-1:0] exp_params;
      bit inv;
      int m, first_c, last_c, c;
      bit leak = 0, unstable = 0, spurious = 0;

      // Reference model of one exchange
      inv = (n <= int'(MP));
      exp_params = '0;
      if (!inv) begin
         expq = '{8'hFF, cid, 8'h00};
         exp_err++;
      end else begin
         m = (rlen > int'(MR)) ? int'(MR) : rlen;
         if (rlen > int'(MR)) exp_err++;
         expq = '{8'h01, cid, 8'(m)};
         for (int k = 0; k < m; k++) expq.push_back(rb[k]);
         for (int k = 0; k < n; k++) exp_params[8*k +: 8] = pb[k];
      end
      for (int k = 0; k < int'(MR); k++) rsp_dat[8*k +: 8] = rb[k];
      rsp_len = 8'(rlen);

      send_byte(method, gap_pct, first_c);
      send_byte(cid, gap_pct, c);
      send_byte(8'(n), gap_pct, c);
      for (int k = 0; k < n; k++) send_byte(pb[k], gap_pct, c);
      @(negedge clock);
      in_valid = 1'b0;
      #1;
      if (inv) check("req_valid_rise", req_valid, 1);
      else     check("drain_out_valid_rise", out_valid, 1);

      fork
         begin : user
            bit hs;
            int budget;
            if (inv) begin
               check("req_method", req_method, method);
               check("req_call_id", req_call_id, cid);
               check("req_nparams", req_nparams, 8'(n));
               check("req_params", req_params, exp_params);
               hs = 0;
               budget = 200;
               while (!hs && budget > 0) begin
                  req_ready = fast || ($urandom_range(1) == 1);
                  hs = req_valid && req_ready;
                  @(posedge clock);
                  @(negedge clock);
                  #1;
                  budget--;
               end
               req_ready = 1'b0;
               check("rsp_ready_rise", rsp_ready, 1);
               hs = 0;
               budget = 200;
               while (!hs && budget > 0) begin
                  rsp_valid = fast || ($urandom_range(1) == 1);
                  hs = rsp_valid && rsp_ready;
                  @(posedge clock);
                  @(negedge clock);
                  #1;
                  budget--;
               end
               rsp_valid = 1'b0;
               check("out_valid_rise", out_valid, 1);
            end
         end
         begin : collector
            bit hold = 0;
            logic [7:0] held;
            int budget = 600;
            while (gotq.size() < expq.size() && budget > 0) begin
               if (!inv && req_valid) spurious = 1;
               if (in_ready) leak = 1;
               if (hold && (!out_valid || out_dat !== held)) unstable = 1;
               out_ready = (ordy_pct >= 100) || ($urandom_range(99) < ordy_pct);
               if (out_valid && out_ready) begin
                  gotq.push_back(out_dat);
                  last_c = cycle;
               end
               hold = out_valid && !out_ready;
               held = out_dat;
               @(posedge clock);
               @(negedge clock);
               #1;
               budget--;
            end
            out_ready = 1'b0;
            check("in_ready_return", in_ready, 1);
            check("out_valid_idle", out_valid, 0);
         end
      join

      check("rsp_size", gotq.size(), expq.size());
      for (int k = 0; k < expq.size() && k < gotq.size(); k++)
         check($sformatf("rsp_byte%0d", k), gotq[k], expq[k]);
      check("no_rx_during_call", leak, 0);
      check("out_dat_stable", unstable, 0);
      check("no_invoke_on_drain", spurious, 0);
      check("err_count", err_count, 16'(exp_err));
      if (inv) check("req_held", {req_method, req_call_id, req_params}, {method, cid, exp_params});
      if (fast) check("turnaround", last_c - first_c + 1, 3 + n + 1 + 1 + expq.size());
   endtask

   initial begin
      int c;
      reset = 1'b1;
      in_valid = 1'b0;
      in_dat = 8'h00;
      out_ready = 1'b0;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_len = 8'h00;
      rsp_dat = '0;
      repeat (3) @(negedge clock);
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out", {out_valid, out_dat}, 0);
      check("rst_req_valid", req_valid, 0);
      check("rst_req_fields", {req_method, req_call_id, req_nparams, req_params}, 0);
      check("rst_rsp_ready", rsp_ready, 0);
      check("rst_err", err_count, 0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("in_ready_after_rst", in_ready, 1);

      // Basic call: two params, one return byte
      pb[0] = 8'h11; pb[1] = 8'h22; rb[0] = 8'h99;
      run_txn(8'h05, 8'h2A, 2, 1, 0, 100, 0);
      // Empty call with tied-high handshakes: minimum turnaround, no data phase
      run_txn(8'h07, 8'h03, 0, 0, 0, 100, 1);
      // Oversized request is drained and answered with an error status
      for (int k = 0; k < 9; k++) pb[k] = 8'($urandom);
      run_txn(8'h09, 8'h44, 9, 0, 0, 100, 0);
      // Oversized return is truncated
      for (int k = 0; k < 6; k++) rb[k] = 8'hA1 + 8'(k);
      run_txn(8'h02, 8'h10, 0, 6, 0, 100, 0);
      // First scenario again under gaps and backpressure
      pb[0] = 8'h11; pb[1] = 8'h22; rb[0] = 8'h99;
      run_txn(8'h05, 8'h2A, 2, 1, 40, 50, 0);
      // Random exchanges
      for (int t = 0; t < 8; t++) begin
         for (int k = 0; k < 12; k++) begin
            pb[k] = 8'($urandom);
            rb[k] = 8'($urandom);
         end
         run_txn(8'($urandom), 8'($urandom), int'($urandom_range(10)), int'($urandom_range(6)),
                 int'($urandom_range(50)), 30 + int'($urandom_range(70)), 0);
      end

      // Abort a frame partway through its parameters
      send_byte(8'h05, 0, c);
      send_byte(8'h2A, 0, c);
      send_byte(8'h04, 0, c);
      send_byte(8'h11, 0, c);
      @(negedge clock);
      in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_req", {req_valid, req_method, req_call_id, req_nparams, req_params}, 0);
      check("abort_err", err_count, 0);
      reset = 1'b0;
      exp_err = 0;
      run_txn(8'h01, 8'h55, 0, 0, 0, 100, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tblink_rpc_rsp_engine.md
# tblink_rpc_rsp_engine

Synthesizable HDL-side responder for TBLink RPC calls. Accepts request frames from a byte stream (the link toward the testbench endpoint), deserializes method id, call id and parameters, and presents one call at a time to a user method port. Accepts the user's return data and serializes a response frame that carries the originating call id back over an outbound byte stream. It sits between the link transport and the user BFM logic, acting as the target end of the invoke / invoke-response exchange.

## Interface
Parameters:
- MAX_PARAMS, 8, maximum parameter bytes per request (1..255)
- MAX_RSP, 4, maximum return bytes per response (1..255)

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_dat  in  8  inbound request byte
- in_valid  in  1  inbound byte valid
- in_ready  out  1  engine accepts inbound byte
- out_dat  out  8  outbound response byte
- out_valid  out  1  outbound byte valid
- out_ready  in  1  link accepts outbound byte
- req_valid  out  1  call presented to user
- req_ready  in  1  user accepts call
- req_method  out  8  method id
- req_call_id  out  8  call id
- req_nparams  out  8  parameter byte count
- req_params  out  8*MAX_PARAMS  parameters; byte k at [8k+7:8k], first received is k=0; unused bytes zero
- rsp_valid  in  1  user return data valid
- rsp_ready  out  1  engine accepts return data
- rsp_len  in  8  return byte count
- rsp_dat  in  8*MAX_RSP  return bytes, byte k at [8k+7:8k]
- err_count  out  16  count of malformed requests and truncated responses, saturating

## Operation
- Request frame: METHOD, CALL_ID, LEN=N, then N parameter bytes.
- Response frame: STATUS (0x01 ok, 0xFF error), CALL_ID, LEN=M, then M bytes.
- States: RX_METHOD, RX_CALLID, RX_LEN, RX_PARAMS, DRAIN, INVOKE, WAIT_RSP, TX_STATUS, TX_CALLID, TX_LEN, TX_DATA.
- RX_METHOD -> RX_CALLID -> RX_LEN on each accepted byte. In RX_LEN: N=0 -> INVOKE; N<=MAX_PARAMS -> RX_PARAMS; N>MAX_PARAMS -> DRAIN.
- RX_PARAMS: store byte at index count. After the Nth byte -> INVOKE.
- DRAIN: discard N bytes, increment err_count, then -> TX_STATUS with status 0xFF, M=0. User port is not invoked.
- INVOKE: req_valid=1. On req_valid&&req_ready -> WAIT_RSP. req_* fields are held stable until the response frame completes.
- WAIT_RSP: rsp_ready=1. On handshake, capture rsp_dat and M=min(rsp_len,MAX_RSP). If rsp_len>MAX_RSP, increment err_count and send the truncated data with status 0x01. Then -> TX_STATUS.
- TX states: out_valid=1, advancing on out_ready. M=0 skips TX_DATA. After the last byte -> RX_METHOD.
- One call is outstanding at a time. No inbound bytes are accepted from INVOKE through the end of TX.
- err_count saturates at 0xFFFF.

## Timing
- Reset values: in_ready=0, out_valid=0, out_dat=0, req_valid=0, req_* fields=0, rsp_ready=0, err_count=0. State resets to RX_METHOD.
- in_ready = RX state (RX_METHOD, RX_CALLID, RX_LEN, RX_PARAMS, DRAIN) && !reset. It is 1 in the first cycle after reset deasserts.
- Each inbound byte is consumed in the cycle it is handshaken; there are no bubbles while in_valid is held high.
- req_valid rises on the cycle after the last request byte is accepted.
- rsp_ready rises on the cycle after the req handshake.
- out_valid rises on the cycle after the rsp handshake, or after the last drained byte.
- out_dat is stable while out_valid && !out_ready.
- in_ready returns to 1 on the cycle after the final response byte handshake.
- Minimum turnaround, request N=0 with req_ready and rsp_valid tied high: 3 in + 1 + 1 + 3 out cycles.
- Reset mid-frame (any state): the partial request is discarded, no response is emitted, and all outputs return to reset values on the next edge.

## Test plan
- Request 05,2A,02,11,22 with user returning len 1 data 0x99 -> req_method=05, req_call_id=2A, req_nparams=2, req_params[15:0]=0x2211, upper bytes 0; response 01,2A,01,99.
- Request 07,03,00 with rsp_len=0 -> invoke with req_nparams=0; response 01,03,00; no TX_DATA cycle.
- Request with N=MAX_PARAMS+1 (9), call id 0x44, followed by 9 bytes -> req_valid never asserts; response FF,44,00; err_count=1.
- rsp_len=6 with MAX_RSP=4, data 0xA1..A6, call id 0x10 -> response 01,10,04,A1,A2,A3,A4; err_count increments by 1.
- out_ready toggled randomly and in_valid gapped during the first scenario -> identical byte sequence; out_dat stable under backpressure; no bytes accepted during INVOKE/WAIT_RSP/TX.
- Reset asserted mid RX_PARAMS, then a clean request 01,55,00 -> no response for the aborted frame; the clean request produces 01,55,00 with err_count=0.
